adrv9001_axis_pattern_gen: RTL and testbench
============================================

ADRV9001_AXIS_PATTERN_GEN -- requirements
Module: adrv9001_axis_pattern_gen

Interface
REQ-001 The block SHALL have parameter RAMP_STEP, default 16'd1: ramp increment per accepted beat.
REQ-002 The block SHALL have parameter PRBS_SEED, default 15'h7FFF: LFSR load value; must be non-zero.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all logic is synchronous to its rising edge.
REQ-004 The block SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 The block SHALL have port enable, input, 1: a rising edge starts a burst; low requests stop.
REQ-006 The block SHALL have port mode, input, 2: pattern select (0 ramp, 1 fixed, 2 PRBS15, 3 zero); sampled at burst start only.
REQ-007 The block SHALL have port fixed_data, input, 32: word sent in mode 1; sampled at burst start.
REQ-008 The block SHALL have port burst_len, input, 16: beats per burst, 0 = continuous; sampled at burst start.
REQ-009 The block SHALL have port m_axis_tdata, output, 32: IQ word, I in [31:16], Q in [15:0].
REQ-010 The block SHALL have port m_axis_tvalid, output, 1: AXIS valid.
REQ-011 The block SHALL have port m_axis_tready, input, 1: AXIS ready from the ADRV9001 TX path.
REQ-012 The block SHALL have port m_axis_tlast, output, 1: high on the final beat of a finite burst.
REQ-013 The block SHALL have port busy, output, 1: high in state RUN.
REQ-014 The block SHALL have port beat_cnt, output, 16: beats accepted in the current or last burst, saturating at 16'hFFFF.

Function
REQ-015 The state machine SHALL have states IDLE, RUN and DONE.
REQ-016 In IDLE, a registered rising edge of enable seen at cycle N SHALL latch mode, fixed_data and burst_len, clear beat_cnt, load the generators, and enter RUN with m_axis_tvalid high at cycle N+1.
REQ-017 A beat SHALL be accepted when m_axis_tvalid and m_axis_tready are both high; tdata and tlast SHALL stay stable while tvalid is high and tready is low.
REQ-018 Ramp mode SHALL send tdata = {r, r}; r starts at 0 and adds RAMP_STEP modulo 2^16 after each accepted beat.
REQ-019 PRBS mode SHALL send tdata = {1'b0, lfsr, 1'b0, lfsr}, using the x^15+x^14+1 Fibonacci LFSR seeded with PRBS_SEED, advanced one step after each accepted beat.
REQ-020 Fixed mode SHALL send the latched fixed_data on every beat; zero mode SHALL send 32'h0.
REQ-021 For burst_len = L > 0, tlast SHALL be high on beat L; acceptance of beat L SHALL move the FSM to DONE with tvalid low on the next cycle.
REQ-022 For burst_len = 0, tlast SHALL stay low and RUN SHALL continue until enable goes low.
REQ-023 When enable goes low in RUN, a beat with tvalid high SHALL be held until it is accepted, then the FSM SHALL enter IDLE; when tvalid is low, the FSM SHALL enter IDLE on the next cycle. No new beat SHALL be presented after enable is sampled low.
REQ-024 The FSM SHALL leave DONE for IDLE only when enable is low; a high enable level SHALL NOT retrigger a burst.
REQ-025 Changes to mode, fixed_data or burst_len during RUN SHALL have no effect until the next burst.

Reset
REQ-026 When rst is high, the block SHALL enter IDLE, with m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0 and beat_cnt=0. The ramp SHALL reset to 0, the LFSR to PRBS_SEED, and the enable edge register to 0.
REQ-027 A reset asserted mid-burst SHALL drop m_axis_tvalid on the next cycle, regardless of tready.
REQ-028 When enable is already high as rst is released, the block SHALL NOT start a burst until enable goes low and then high again.

Configuration
REQ-029 With macro ADRV9001_PATTERN_GEN_PRBS_EN defined, the LFSR and mode 2 SHALL be implemented as specified in REQ-019.
REQ-030 With ADRV9001_PATTERN_GEN_PRBS_EN undefined, no LFSR logic SHALL be present and mode 2 SHALL behave as mode 3 (zero).

Verification
REQ-031 Ramp burst: mode=0, burst_len=4, tready=1, enable rises -> tdata 0x00000000, 0x00010001, 0x00020002, 0x00030003; tlast on beat 4; beat_cnt=4; state DONE.
REQ-032 Backpressure: mode=1, fixed_data=0xDEADBEEF, burst_len=3, tready toggling 1/0 -> exactly 3 beats of 0xDEADBEEF, tdata/tlast stable while stalled, tlast only on beat 3.
REQ-033 PRBS: mode=2 with the macro defined, default seed -> first two beats 0x7FFF7FFF then 0x7FFE7FFE; with the macro undefined -> 0x00000000.
REQ-034 Continuous stop: burst_len=0, tready=0 when enable falls with a beat pending -> tvalid stays high until the tready pulse, then IDLE; no extra beat.
REQ-035 Reset mid-burst: assert rst after 2 of 10 beats -> tvalid=0, beat_cnt=0 next cycle; enable held high after release -> no new burst until it toggles.

Source files
------------

// File: rtl/adrv9001_axis_pattern_gen_if.sv
// AXI-Stream IQ link between the pattern generator and the ADRV9001 TX path.
// The master drives tdata/tvalid/tlast and the slave returns tready.
interface adrv9001_axis_pattern_gen_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/adrv9001_axis_pattern_gen.sv
// ADRV9001 TX test pattern source (ramp/fixed/PRBS15/zero); tvalid rises one cycle after an enable edge, and beats hold under tready backpressure.
// PRBS15 generation exists only when ADRV9001_PATTERN_GEN_PRBS_EN is defined; otherwise mode 2 sends zeros.
module adrv9001_axis_pattern_gen #(
  parameter logic [15:0] RAMP_STEP = 16'd1,
  parameter logic [14:0] PRBS_SEED = 15'h7FFF
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic [1:0]                         mode,
  input  logic [31:0]                        fixed_data,
  input  logic [15:0]                        burst_len,
  adrv9001_axis_pattern_gen_if.master        m_axis,
  output logic                               busy,
  output logic [15:0]                        beat_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_RAMP  = 2'd0;
  localparam logic [1:0] MODE_FIXED = 2'd1;
  localparam logic [1:0] MODE_PRBS  = 2'd2;

  if (PRBS_SEED == 15'd0) begin : g_seed_chk
    $error("PRBS_SEED must be non-zero");
  end

  state_t      r_state;
  logic        r_vld;
  logic [1:0]  r_mode;
  logic [31:0] r_fixed;
  logic [15:0] r_len;
  logic [15:0] r_cnt;
  logic [15:0] r_ramp;
  logic        r_en_d;
  logic        r_armed;

  state_t      w_state_nxt;
  logic        w_vld_nxt;
  logic [1:0]  w_mode_nxt;
  logic [31:0] w_fixed_nxt;
  logic [15:0] w_len_nxt;
  logic [15:0] w_cnt_nxt;
  logic [15:0] w_ramp_nxt;

  logic        w_rise;
  logic        w_acc;
  logic        w_last;
  logic [31:0] w_tdata;

`ifdef ADRV9001_PATTERN_GEN_PRBS_EN
  logic [14:0] r_lfsr;
  logic [14:0] w_lfsr_nxt;
  logic [14:0] w_lfsr_step;

  // x^15 + x^14 + 1, Fibonacci form, shifting towards the MSB
  assign w_lfsr_step = {r_lfsr[13:0], r_lfsr[14] ^ r_lfsr[13]};
`endif

  // r_armed blocks a burst until enable has been seen low after reset
  assign w_rise = enable & ~r_en_d & r_armed;
  assign w_acc  = r_vld & m_axis.tready;
  assign w_last = r_vld && (r_len != 16'd0) && (r_cnt == (r_len - 16'd1));

  always_comb begin
    w_state_nxt = r_state;
    w_vld_nxt   = r_vld;
    w_mode_nxt  = r_mode;
    w_fixed_nxt = r_fixed;
    w_len_nxt   = r_len;
    w_cnt_nxt   = r_cnt;
    w_ramp_nxt  = r_ramp;
`ifdef ADRV9001_PATTERN_GEN_PRBS_EN
    w_lfsr_nxt  = r_lfsr;
`endif

    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_nxt = ST_RUN;
          w_vld_nxt   = 1'b1;
          w_mode_nxt  = mode;
          w_fixed_nxt = fixed_data;
          w_len_nxt   = burst_len;
          w_cnt_nxt   = 16'd0;
          w_ramp_nxt  = 16'd0;
`ifdef ADRV9001_PATTERN_GEN_PRBS_EN
          w_lfsr_nxt  = PRBS_SEED;
`endif
        end
      end

      ST_RUN: begin
        if (w_acc) begin
          if (r_cnt != 16'hFFFF) begin
            w_cnt_nxt = r_cnt + 16'd1;
          end
          w_ramp_nxt = r_ramp + RAMP_STEP;
`ifdef ADRV9001_PATTERN_GEN_PRBS_EN
          w_lfsr_nxt = w_lfsr_step;
`endif
        end

        // a pending beat is never withdrawn: stop only once it is taken
        if (w_acc && w_last) begin
          w_state_nxt = ST_DONE;
          w_vld_nxt   = 1'b0;
        end else if (!enable && (w_acc || !r_vld)) begin
          w_state_nxt = ST_IDLE;
          w_vld_nxt   = 1'b0;
        end
      end

      ST_DONE: begin
        if (!enable) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_vld_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_vld   <= 1'b0;
      r_mode  <= MODE_RAMP;
      r_fixed <= 32'd0;
      r_len   <= 16'd0;
      r_cnt   <= 16'd0;
      r_ramp  <= 16'd0;
      r_en_d  <= 1'b0;
      r_armed <= 1'b0;
`ifdef ADRV9001_PATTERN_GEN_PRBS_EN
      r_lfsr  <= PRBS_SEED;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_vld   <= w_vld_nxt;
      r_mode  <= w_mode_nxt;
      r_fixed <= w_fixed_nxt;
      r_len   <= w_len_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ramp  <= w_ramp_nxt;
      r_en_d  <= enable;
      r_armed <= r_armed | ~enable;
`ifdef ADRV9001_PATTERN_GEN_PRBS_EN
      r_lfsr  <= w_lfsr_nxt;
`endif
    end
  end

  // data is a pure function of held registers, so it is stable under stall
  always_comb begin
    w_tdata = 32'd0;
    case (r_mode)
      MODE_RAMP:  w_tdata = {r_ramp, r_ramp};
      MODE_FIXED: w_tdata = r_fixed;
`ifdef ADRV9001_PATTERN_GEN_PRBS_EN
      MODE_PRBS:  w_tdata = {1'b0, r_lfsr, 1'b0, r_lfsr};
`endif
      default:    w_tdata = 32'd0;
    endcase
  end

  assign m_axis.tdata  = w_tdata;
  assign m_axis.tvalid = r_vld;
  assign m_axis.tlast  = w_last;
  assign busy          = (r_state == ST_RUN);
  assign beat_cnt      = r_cnt;

endmodule

// File: tb/tb_adrv9001_axis_pattern_gen.sv
// Directed bench for adrv9001_axis_pattern_gen: ramp, backpressure, PRBS, continuous stop and reset.
// PRBS expectations follow ADRV9001_PATTERN_GEN_PRBS_EN as seen by this compile.
module tb_adrv9001_axis_pattern_gen;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [1:0]  mode;
  logic [31:0] fixed_data;
  logic [15:0] burst_len;
  logic        busy;
  logic [15:0] beat_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] q_dat[$];
  logic        q_last[$];

  logic        stall_d    = 1'b0;
  logic [31:0] stall_dat  = 32'd0;
  logic        stall_last = 1'b0;

  adrv9001_axis_pattern_gen_if axis ();

  adrv9001_axis_pattern_gen #(
    .RAMP_STEP (16'd1),
    .PRBS_SEED (15'h7FFF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .mode       (mode),
    .fixed_data (fixed_data),
    .burst_len  (burst_len),
    .m_axis     (axis),
    .busy       (busy),
    .beat_cnt   (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_not_busy(input string tag, input int max_cycles);
    int n = 0;
    while (busy && n < max_cycles) begin
      tick();
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  // record accepted beats and verify that a stalled beat is held unchanged
  always @(negedge clk) begin
    if (stall_d) begin
      check("stall_vld", {31'd0, axis.tvalid}, 32'd1);
      check("stall_dat", axis.tdata, stall_dat);
      check("stall_last", {31'd0, axis.tlast}, {31'd0, stall_last});
    end
    stall_d    = axis.tvalid && !axis.tready && !rst;
    stall_dat  = axis.tdata;
    stall_last = axis.tlast;
    if (axis.tvalid && axis.tready && !rst) begin
      q_dat.push_back(axis.tdata);
      q_last.push_back(axis.tlast);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_ramp [4];
    logic [31:0] exp_prbs [2];
    int n;

    exp_ramp[0] = 32'h0000_0000;
    exp_ramp[1] = 32'h0001_0001;
    exp_ramp[2] = 32'h0002_0002;
    exp_ramp[3] = 32'h0003_0003;
`ifdef ADRV9001_PATTERN_GEN_PRBS_EN
    exp_prbs[0] = 32'h7FFF_7FFF;
    exp_prbs[1] = 32'h7FFE_7FFE;
`else
    exp_prbs[0] = 32'h0000_0000;
    exp_prbs[1] = 32'h0000_0000;
`endif

    rst         = 1'b1;
    enable      = 1'b0;
    mode        = 2'd0;
    fixed_data  = 32'd0;
    burst_len   = 16'd0;
    axis.tready = 1'b0;
    tick();
    tick();
    check("rst_tvalid", {31'd0, axis.tvalid}, 32'd0);
    check("rst_tlast", {31'd0, axis.tlast}, 32'd0);
    check("rst_tdata", axis.tdata, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_beat_cnt", {16'd0, beat_cnt}, 32'd0);
    rst = 1'b0;
    tick();

    // ramp burst of 4
    q_dat.delete();
    q_last.delete();
    mode        = 2'd0;
    burst_len   = 16'd4;
    axis.tready = 1'b1;
    enable      = 1'b1;
    tick();
    check("t1_first_vld", {31'd0, axis.tvalid}, 32'd1);
    check("t1_first_busy", {31'd0, busy}, 32'd1);
    wait_not_busy("t1_timeout", 20);
    check("t1_beats", q_dat.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_dat%0d", i), q_dat[i], exp_ramp[i]);
      check($sformatf("t1_last%0d", i), {31'd0, q_last[i]}, (i == 3) ? 32'd1 : 32'd0);
    end
    check("t1_beat_cnt", {16'd0, beat_cnt}, 32'd4);
    check("t1_done_vld", {31'd0, axis.tvalid}, 32'd0);
    repeat (4) tick();
    check("t1_no_retrig_vld", {31'd0, axis.tvalid}, 32'd0);
    check("t1_no_retrig_beats", q_dat.size(), 32'd4);
    enable = 1'b0;
    tick();
    tick();

    // fixed word under alternating backpressure; input changes mid-burst ignored
    q_dat.delete();
    q_last.delete();
    mode        = 2'd1;
    fixed_data  = 32'hDEAD_BEEF;
    burst_len   = 16'd3;
    axis.tready = 1'b0;
    enable      = 1'b1;
    tick();
    n = 0;
    while (busy && n < 40) begin
      axis.tready = ~axis.tready;
      if (n == 1) begin
        mode       = 2'd0;
        fixed_data = 32'h1234_5678;
        burst_len  = 16'd1;
      end
      tick();
      n++;
    end
    check("t2_timeout", {31'd0, busy}, 32'd0);
    check("t2_beats", q_dat.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t2_dat%0d", i), q_dat[i], 32'hDEAD_BEEF);
      check($sformatf("t2_last%0d", i), {31'd0, q_last[i]}, (i == 2) ? 32'd1 : 32'd0);
    end
    check("t2_beat_cnt", {16'd0, beat_cnt}, 32'd3);
    enable = 1'b0;
    tick();
    tick();

    // PRBS15 burst of 2
    q_dat.delete();
    q_last.delete();
    mode        = 2'd2;
    burst_len   = 16'd2;
    axis.tready = 1'b1;
    enable      = 1'b1;
    tick();
    wait_not_busy("t3_timeout", 20);
    check("t3_beats", q_dat.size(), 32'd2);
    check("t3_dat0", q_dat[0], exp_prbs[0]);
    check("t3_dat1", q_dat[1], exp_prbs[1]);
    check("t3_last0", {31'd0, q_last[0]}, 32'd0);
    check("t3_last1", {31'd0, q_last[1]}, 32'd1);
    enable = 1'b0;
    tick();
    tick();

    // continuous ramp stopped while a beat is stalled
    q_dat.delete();
    q_last.delete();
    mode        = 2'd0;
    burst_len   = 16'd0;
    axis.tready = 1'b1;
    enable      = 1'b1;
    repeat (4) tick();
    check("t4_beats_before", q_dat.size(), 32'd3);
    axis.tready = 1'b0;
    enable      = 1'b0;
    repeat (3) tick();
    check("t4_hold_vld", {31'd0, axis.tvalid}, 32'd1);
    check("t4_hold_dat", axis.tdata, 32'h0003_0003);
    check("t4_hold_last", {31'd0, axis.tlast}, 32'd0);
    check("t4_hold_busy", {31'd0, busy}, 32'd1);
    axis.tready = 1'b1;
    tick();
    check("t4_stop_vld", {31'd0, axis.tvalid}, 32'd0);
    check("t4_stop_busy", {31'd0, busy}, 32'd0);
    check("t4_stop_cnt", {16'd0, beat_cnt}, 32'd4);
    repeat (3) tick();
    check("t4_no_extra", q_dat.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_last%0d", i), {31'd0, q_last[i]}, 32'd0);
    end

    // reset mid-burst with enable held high across release
    q_dat.delete();
    q_last.delete();
    mode        = 2'd0;
    burst_len   = 16'd10;
    axis.tready = 1'b1;
    enable      = 1'b1;
    repeat (3) tick();
    check("t5_cnt_before", {16'd0, beat_cnt}, 32'd2);
    rst         = 1'b1;
    axis.tready = 1'b0;
    tick();
    check("t5_rst_vld", {31'd0, axis.tvalid}, 32'd0);
    check("t5_rst_cnt", {16'd0, beat_cnt}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_dat", axis.tdata, 32'd0);
    rst = 1'b0;
    repeat (5) tick();
    check("t5_held_vld", {31'd0, axis.tvalid}, 32'd0);
    check("t5_held_busy", {31'd0, busy}, 32'd0);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    check("t5_restart_vld", {31'd0, axis.tvalid}, 32'd1);
    check("t5_restart_dat", axis.tdata, 32'd0);
    check("t5_restart_busy", {31'd0, busy}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
